disp_sched: RTL and testbench

Round-robin scheduler that shares the 8-bit display/LED output bus between up to `NUM_REQ` pattern sources. Each source raises a request and is granted the display for a fixed dwell time, counted in prescaler ticks, or until it withdraws its request. The block sits between the pattern-generating FSMs and the top-level `uo_out` drive, and owns the display-rate prescaler.

---
 rtl/disp_sched_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/disp_sched.sv | 134 +++++++++++++
 tb/tb_disp_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display round-robin scheduler.
// Optional BLANK gap state is enabled by DISP_SCHED_BLANK_EN.
package disp_sched_pkg;

    localparam int unsigned PRESC_W = 24;
    localparam int unsigned DWELL_W = 8;
    localparam logic [7:0]  BLANK_PAT = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StBlank
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Display-rate prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
// A synchronous clear restarts the count so each grant or blank period starts on a full tick.
module tick_prescaler
    import disp_sched_pkg::*;
#(
    parameter logic [PRESC_W-1:0] DIV = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    logic [PRESC_W-1:0] count_q;

    assign tick = ena && (count_q == (DIV - 24'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr || tick) begin
            count_q <= '0;
        end else if (ena) begin
            count_q <= count_q + 24'd1;
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Round-robin scheduler granting the 8-bit display bus to one pattern source at a time.
// Define DISP_SCHED_BLANK_EN to insert a one-tick blank period after every release.
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int unsigned        NUM_REQ     = 4,
    parameter logic [PRESC_W-1:0] TICK_DIV    = 24'd10_000_000,
    parameter logic [DWELL_W-1:0] DWELL_TICKS = 8'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] pat_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           disp_out,
    output logic                 busy,
    output logic                 tick
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    // A zero dwell setting behaves as a single tick.
    localparam logic [DWELL_W-1:0] DWELL_LAST =
        (DWELL_TICKS == '0) ? '0 : DWELL_TICKS - 8'd1;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [DWELL_W-1:0] dwell_q;

    logic [7:0]         pat_arr [NUM_REQ];
    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic               grant_c;
    logic               release_c;
    logic               presc_clr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pat
        assign pat_arr[i] = pat_in[8*i +: 8];
    end

    // Search upward from the slot after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = found;
    end

    // While holding, ptr_q is the granted source.
    assign grant_c   = (state_q == StIdle) && ena && found;
    assign release_c = (tick && (dwell_q == DWELL_LAST)) || !req[ptr_q];

`ifdef DISP_SCHED_BLANK_EN
    assign presc_clr = grant_c || ((state_q == StHold) && release_c);
`else
    assign presc_clr = grant_c;
`endif

    assign busy = (state_q != StIdle);

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            dwell_q  <= '0;
            gnt      <= '0;
            disp_out <= BLANK_PAT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    gnt      <= '0;
                    disp_out <= BLANK_PAT;
                    if (grant_c) begin
                        gnt     <= win_onehot;
                        ptr_q   <= win_idx;
                        dwell_q <= '0;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    disp_out <= pat_arr[ptr_q];
                    if (release_c) begin
                        gnt <= '0;
`ifdef DISP_SCHED_BLANK_EN
                        state_q <= StBlank;
`else
                        state_q <= StIdle;
`endif
                    end else if (tick) begin
                        dwell_q <= dwell_q + 8'd1;
                    end
                end
`ifdef DISP_SCHED_BLANK_EN
                StBlank: begin
                    gnt      <= '0;
                    disp_out <= BLANK_PAT;
                    if (tick) begin
                        state_q <= StIdle;
                    end
                end
`endif
                default: begin
                    gnt      <= '0;
                    disp_out <= BLANK_PAT;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: directed scenarios plus randomized traffic against
// a grant-level reference model (owner, enabled cycles held, free-running prescaler phase).
module tb_disp_sched;

    localparam int NR  = 4;
    localparam int TDI = 4;
    localparam int DWE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [3:0]    req = '0;
    logic [31:0]   pat_in = '0;
    logic [3:0]    gnt;
    logic [7:0]    disp_out;
    logic          busy;
    logic          tick;

    always #5 clk = ~clk;

    disp_sched #(
        .NUM_REQ     (NR),
        .TICK_DIV    (24'd4),
        .DWELL_TICKS (8'd2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .req      (req),
        .pat_in   (pat_in),
        .gnt      (gnt),
        .disp_out (disp_out),
        .busy     (busy),
        .tick     (tick)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: values the registers hold during the current cycle.
    int         m_owner;
    int         m_ptr;
    int         m_presc;
    int         m_e;
    bit         m_blank;
    logic [7:0] m_disp;
    logic [3:0] s_gnt;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = NR - 1;
        m_presc = 0;
        m_e     = 0;
        m_blank = 1'b0;
        m_disp  = 8'h00;
    endfunction

    function automatic void model_edge(input bit tk);
        int nxt_presc;
        nxt_presc = ena ? (tk ? 0 : m_presc + 1) : m_presc;
        if (m_owner >= 0) begin
            m_disp = pat_in[8*m_owner +: 8];
            if (!req[m_owner] || (tk && m_e == DWE * TDI - 1)) begin
                m_owner = -1;
`ifdef DISP_SCHED_BLANK_EN
                m_blank   = 1'b1;
                nxt_presc = 0;
`endif
            end else if (ena) begin
                m_e++;
            end
        end else if (m_blank) begin
            m_disp = 8'h00;
            if (tk) m_blank = 1'b0;
        end else begin
            m_disp = 8'h00;
            if (ena && req != 4'b0) begin
                for (int i = 1; i <= NR; i++) begin
                    int c;
                    c = (m_ptr + i) % NR;
                    if (req[c]) begin
                        m_owner   = c;
                        m_ptr     = c;
                        m_e       = 0;
                        nxt_presc = 0;
                        break;
                    end
                end
            end
        end
        m_presc = nxt_presc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; leaves at the next falling edge.
    task automatic step();
        bit exp_tick;
        #1;
        exp_tick = ena && (m_presc == TDI - 1);
        s_gnt    = gnt;
        check("gnt", 32'(gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        check("disp_out", 32'(disp_out), 32'(m_disp));
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_blank));
        check("tick", 32'(tick), 32'(exp_tick));
        model_edge(exp_tick);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        req   = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_disp", 32'(disp_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Measures the first grant's length and the following gap; ena drops for 10 cycles
    // once off_at grant cycles have been seen (off_at = 0 disables the drop).
    task automatic measure(input int off_at, output int len, output int gap);
        int ph;
        int off_left;
        ph = 0; off_left = 0; len = 0; gap = 0;
        for (int c = 0; c < 60; c++) begin
            ena = (off_left > 0) ? 1'b0 : 1'b1;
            step();
            if (off_left > 0) off_left--;
            case (ph)
                0: if (s_gnt != 0) begin ph = 1; len = 1; end
                1: if (s_gnt != 0) begin
                       len++;
                       if (off_at != 0 && len == off_at) off_left = 10;
                   end else begin
                       ph = 2; gap = 1;
                   end
                2: if (s_gnt != 0) ph = 3; else gap++;
                default: ;
            endcase
        end
    endtask

    initial begin
        int len;
        int gap;
        int ngr;
        int bit_sel;
        logic [3:0] prev;
        logic [3:0] order [5];
        bit got;

        pat_in = {8'h44, 8'h33, 8'h22, 8'h11};
        @(negedge clk);
        do_reset();

        // Single requester: full dwell, one idle cycle, re-grant.
        req = 4'b0001;
        measure(0, len, gap);
        check("dwell_len", 32'(len), 32'(DWE * TDI));
`ifdef DISP_SCHED_BLANK_EN
        check("gap_len", 32'(gap), 32'(TDI + 1));
`else
        check("gap_len", 32'(gap), 32'd1);
`endif

        // All sources requesting: strict rotation 0,1,2,3,0.
        do_reset();
        req  = 4'b1111;
        ena  = 1'b1;
        ngr  = 0;
        prev = '0;
        for (int c = 0; c < 80 && ngr < 5; c++) begin
            step();
            if (s_gnt != 0 && prev == 0) begin
                order[ngr] = s_gnt;
                ngr++;
            end
            prev = s_gnt;
        end
        check("rr_count", 32'(ngr), 32'd5);
        check("rr_0", 32'(order[0]), 32'h1);
        check("rr_1", 32'(order[1]), 32'h2);
        check("rr_2", 32'(order[2]), 32'h4);
        check("rr_3", 32'(order[3]), 32'h8);
        check("rr_4", 32'(order[4]), 32'h1);

        // Early release of source 2, then source 3 takes over.
        do_reset();
        ena = 1'b1;
        req = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            got = (s_gnt == 4'b0100);
        end
        check("er_granted", 32'(got), 32'd1);
        step();
        step();
        req = 4'b1000;
        step();
        #1;
        check("er_gnt_off", 32'(gnt), 32'd0);
        check("er_disp_lag", 32'(disp_out), 32'h33);
        @(negedge clk);
        model_edge(1'b0);
        // model_edge above mirrors the cycle just skipped (no tick: presc was cleared at grant).
        #1;
        check("er_disp_off", 32'(disp_out), 32'd0);
        check("er_next_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        model_edge(ena && (m_presc == TDI - 1));
        step();

        // ena low for 10 cycles mid-grant stretches the grant by exactly 10.
        do_reset();
        req = 4'b0001;
        measure(3, len, gap);
        check("ena_off_len", 32'(len), 32'(DWE * TDI + 10));

        // Asynchronous reset in the middle of a grant; source 0 wins afterwards.
        req = 4'b1111;
        ena = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_disp", 32'(disp_out), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_win", 32'(s_gnt), 32'h1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) begin
                bit_sel      = $urandom_range(0, 3);
                req[bit_sel] = ~req[bit_sel];
            end
            if ($urandom_range(0, 3) == 0) pat_in = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
